// File: rtl/uart_rx_pkg.sv
// Shared widths, supported prescale values and helpers for the UART RX oversampling front end.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W    = 6;
    localparam int unsigned BIT_CNT_W     = 4;
    localparam int unsigned CALC_W        = PRESCALE_W + 1;
    localparam int unsigned SAMPLE_OFFSET = 1;

    localparam logic [PRESCALE_W-1:0] PSC_8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PSC_16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PSC_32 = PRESCALE_W'(32);

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = BIT_CNT_W'(15);

    // Two-of-three vote across the samples taken around mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Bundle between the RX control FSM / pin path and the oversampling front end.
interface uart_rx_sampler_if
    import uart_rx_pkg::*;
();

    logic                  RX_IN;
    logic                  enable;
    logic                  data_samp_en;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  strt_glitch;

    modport slave (
        input  RX_IN, enable, data_samp_en, PRESCALE,
        output edge_cnt, bit_cnt, sampled_bit, sample_done, strt_glitch
    );

    modport master (
        output RX_IN, enable, data_samp_en, PRESCALE,
        input  edge_cnt, bit_cnt, sampled_bit, sample_done, strt_glitch
    );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// Edge/bit counters pacing the RX controller, with a per-frame latch of the oversampling ratio.
module rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic [PRESCALE_W-1:0] o_psc
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [PRESCALE_W-1:0] r_psc;
    logic [PRESCALE_W-1:0] w_psc;
    logic                  w_frame_start;

    // While idle the live PRESCALE governs; once counting, only the latched copy does.
    assign w_frame_start = (r_edge_cnt == '0);
    assign w_psc         = w_frame_start ? i_prescale : r_psc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_psc      <= '0;
        end else if (!i_enable) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_frame_start) begin
                r_psc <= i_prescale;
            end
            if (r_edge_cnt == w_psc) begin
                r_edge_cnt <= PRESCALE_W'(1);
                if (r_bit_cnt != BIT_CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_psc      = r_psc;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: three samples around mid-bit, majority vote, false-start flag.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    uart_rx_sampler_if.slave  bus
);

    logic [PRESCALE_W-1:0] w_edge_cnt;
    logic [BIT_CNT_W-1:0]  w_bit_cnt;
    logic [PRESCALE_W-1:0] w_psc;

    logic [CALC_W-1:0] w_edge_ext;
    logic [CALC_W-1:0] w_mid;
    logic [CALC_W-1:0] w_lo;
    logic [CALC_W-1:0] w_hi;
    logic              w_active;
    logic              w_vote;

    logic r_s0;
    logic r_s1;
    logic r_sampled_bit;
    logic r_sample_done;
    logic r_strt_glitch;

    rx_edge_bit_counter u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .i_enable   (bus.enable),
        .i_prescale (bus.PRESCALE),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_psc      (w_psc)
    );

    // Window math is one bit wider so MID+1 cannot wrap at the largest ratio.
    assign w_edge_ext = CALC_W'(w_edge_cnt);
    assign w_mid      = CALC_W'(w_psc) >> 1;
    assign w_lo       = w_mid - CALC_W'(SAMPLE_OFFSET);
    assign w_hi       = w_mid + CALC_W'(SAMPLE_OFFSET);
    assign w_active   = bus.enable && bus.data_samp_en && (w_edge_cnt != '0);
    assign w_vote     = maj3(r_s0, r_s1, bus.RX_IN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0          <= 1'b0;
            r_s1          <= 1'b0;
            r_sampled_bit <= 1'b1;
            r_sample_done <= 1'b0;
            r_strt_glitch <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;
            r_strt_glitch <= 1'b0;
            if (!bus.enable) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
            end else if (w_active) begin
                if (w_edge_ext == w_lo) begin
                    r_s0 <= bus.RX_IN;
                end
                if (w_edge_ext == w_mid) begin
                    r_s1 <= bus.RX_IN;
                end
                if (w_edge_ext == w_hi) begin
                    r_sampled_bit <= w_vote;
                    r_sample_done <= 1'b1;
                    r_strt_glitch <= (w_bit_cnt == '0) && w_vote;
                end
            end
        end
    end

    assign bus.edge_cnt    = w_edge_cnt;
    assign bus.bit_cnt     = w_bit_cnt;
    assign bus.sampled_bit = r_sampled_bit;
    assign bus.sample_done = r_sample_done;
    assign bus.strt_glitch = r_strt_glitch;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler with a scoreboard of expected votes.
module tb_uart_rx_sampler;
    import uart_rx_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_sampler_if bus ();

    uart_rx_sampler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic bit_v;
        logic glitch;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic exp_sb = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Run one bit period: drive samples at MID-1/MID/MID+1 and check counters every edge.
    task automatic run_bit(input int psc, input logic [2:0] pat, input logic samp,
                           input int bc, input logic idle);
        int   mid;
        logic v;
        mid = psc / 2;
        bus.data_samp_en = samp;
        if (samp) begin
            v = (pat[2] & pat[1]) | (pat[2] & pat[0]) | (pat[1] & pat[0]);
            sb_q.push_back('{bit_v: v, glitch: (bc == 0) && v});
            exp_sb = v;
        end
        for (int e = 1; e <= psc; e++) begin
            tick();
            chk("edge_cnt", 32'(bus.edge_cnt), 32'(e));
            chk("bit_cnt", 32'(bus.bit_cnt), 32'(bc));
            chk("sample_done_timing", 32'(bus.sample_done), 32'(samp && (e == mid + 2)));
            if (e == mid + 2) chk("sampled_bit_level", 32'(bus.sampled_bit), 32'(exp_sb));
            bus.RX_IN = (e == mid - 1) ? pat[2] :
                        (e == mid)     ? pat[1] :
                        (e == mid + 1) ? pat[0] : idle;
        end
    endtask

    // Scoreboard side: every sample_done pulse must match the oldest expected vote.
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.sample_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_sample_done", 32'(bus.sample_done), 32'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_sampled_bit", 32'(bus.sampled_bit), 32'(mon_e.bit_v));
                    chk("sb_strt_glitch", 32'(bus.strt_glitch), 32'(mon_e.glitch));
                end
            end else begin
                chk("stray_strt_glitch", 32'(bus.strt_glitch), 32'(0));
            end
        end
    end

    initial begin
        bus.RX_IN        = 1'b1;
        bus.enable       = 1'b0;
        bus.data_samp_en = 1'b0;
        bus.PRESCALE     = PSC_8;

        #12;
        chk("rst_edge_cnt", 32'(bus.edge_cnt), 32'(0));
        chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'(0));
        chk("rst_sampled_bit", 32'(bus.sampled_bit), 32'(1));
        chk("rst_sample_done", 32'(bus.sample_done), 32'(0));
        chk("rst_strt_glitch", 32'(bus.strt_glitch), 32'(0));
        @(negedge CLK);
        RST = 1'b1;
        tick();

        // PSC=8, line held low: valid start bit, wrap to bit 1
        bus.PRESCALE = PSC_8;
        bus.RX_IN    = 1'b0;
        bus.enable   = 1'b1;
        run_bit(8, 3'b000, 1'b1, 0, 1'b0);
        tick();
        chk("psc8_wrap_edge", 32'(bus.edge_cnt), 32'(1));
        chk("psc8_wrap_bit", 32'(bus.bit_cnt), 32'(1));
        bus.enable = 1'b0;
        tick();
        chk("disable_edge", 32'(bus.edge_cnt), 32'(0));
        chk("disable_bit", 32'(bus.bit_cnt), 32'(0));

        // PSC=8, samples 0,1,1: false start
        bus.enable = 1'b1;
        run_bit(8, 3'b011, 1'b1, 0, 1'b0);
        bus.enable = 1'b0;
        tick();

        // PSC=16: 1,0,1 on bit 0, 0,0,1 on bit 1, no capture on bit 2
        bus.PRESCALE = PSC_16;
        bus.RX_IN    = 1'b1;
        bus.enable   = 1'b1;
        run_bit(16, 3'b101, 1'b1, 0, 1'b1);
        run_bit(16, 3'b001, 1'b1, 1, 1'b1);
        run_bit(16, 3'b000, 1'b0, 2, 1'b1);
        bus.enable = 1'b0;
        tick();

        // Mid-frame PRESCALE change only applies to the next frame
        bus.PRESCALE     = PSC_8;
        bus.data_samp_en = 1'b0;
        bus.enable       = 1'b1;
        tick();
        chk("latch_first_edge", 32'(bus.edge_cnt), 32'(1));
        bus.PRESCALE = PSC_16;
        for (int e = 2; e <= 8; e++) begin
            tick();
            chk("latch_edge", 32'(bus.edge_cnt), 32'(e));
        end
        tick();
        chk("latch_wrap8_edge", 32'(bus.edge_cnt), 32'(1));
        chk("latch_wrap8_bit", 32'(bus.bit_cnt), 32'(1));
        bus.enable = 1'b0;
        tick();
        chk("relatch_idle", 32'(bus.edge_cnt), 32'(0));
        bus.enable = 1'b1;
        run_bit(16, 3'b000, 1'b0, 0, 1'b1);
        tick();
        chk("relatch_wrap16_edge", 32'(bus.edge_cnt), 32'(1));
        chk("relatch_wrap16_bit", 32'(bus.bit_cnt), 32'(1));
        bus.enable = 1'b0;
        tick();

        // 20 bits at PSC=8: bit_cnt saturates, then enable drops inside the sample window
        bus.PRESCALE = PSC_8;
        bus.enable   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            run_bit(8, 3'b000, 1'b0, (k > 15) ? 15 : k, 1'b1);
        end
        bus.data_samp_en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("sat_edge", 32'(bus.edge_cnt), 32'(e));
            chk("sat_bit", 32'(bus.bit_cnt), 32'(15));
            bus.RX_IN = 1'b0;
        end
        bus.enable = 1'b0;
        tick();
        chk("drop_edge", 32'(bus.edge_cnt), 32'(0));
        chk("drop_bit", 32'(bus.bit_cnt), 32'(0));
        for (int i = 0; i < 3; i++) begin
            chk("drop_no_sample_done", 32'(bus.sample_done), 32'(0));
            tick();
        end
        chk("drop_sampled_bit_hold", 32'(bus.sampled_bit), 32'(exp_sb));
        bus.data_samp_en = 1'b0;

        // Asynchronous reset mid-frame at PSC=16, edge 9
        bus.PRESCALE     = PSC_16;
        bus.data_samp_en = 1'b1;
        bus.RX_IN        = 1'b1;
        bus.enable       = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk("pre_rst_edge", 32'(bus.edge_cnt), 32'(e));
        end
        chk("pre_rst_sampled_bit", 32'(bus.sampled_bit), 32'(0));
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_edge_cnt", 32'(bus.edge_cnt), 32'(0));
        chk("async_rst_bit_cnt", 32'(bus.bit_cnt), 32'(0));
        chk("async_rst_sampled_bit", 32'(bus.sampled_bit), 32'(1));
        chk("async_rst_sample_done", 32'(bus.sample_done), 32'(0));
        chk("async_rst_strt_glitch", 32'(bus.strt_glitch), 32'(0));
        bus.enable = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        tick();
        chk("post_rst_sample_done", 32'(bus.sample_done), 32'(0));

        chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
